// File: rtl/rr_load_arbiter.sv
// ----------------------------------------------------------------------------
// rr_load_arbiter
//
// Round-robin arbiter sharing one loadable storage register between up to m
// requesters. Each grant becomes a registered single-cycle load strobe (ld_c)
// plus the winner's data (ld_data). These drive the shared register's load
// enable and data inputs directly.
//
// Optional feature macro: LOCK_EN
//   When defined, a per-requester lock input lets a winner hold the register
//   for consecutive loads (LOCKED state) while its req and lock stay high.
//
// Parameters:
//   n        data width (matches the shared register width)
//   m        number of requesters, 2..8
//
// Ports:
//   clk      system clock, rising edge
//   clr      synchronous active-low reset
//   req      per-requester request, held until granted
//   data     packed request data, requester i uses data[i*n +: n]
//   lock     per-requester hold request (LOCK_EN only)
//   gnt      registered one-hot grant, high for the load cycle
//   ld_c     registered load strobe to the shared register
//   ld_data  registered data to the shared register
//   busy     high in any cycle ld_c is high
// ----------------------------------------------------------------------------
module rr_load_arbiter #(
    parameter int n = 4,
    parameter int m = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [m-1:0]     req,
    input  logic [m*n-1:0]   data,
`ifdef LOCK_EN
    input  logic [m-1:0]     lock,
`endif
    output logic [m-1:0]     gnt,
    output logic             ld_c,
    output logic [n-1:0]     ld_data,
    output logic             busy
);

    localparam int PW = (m > 1) ? $clog2(m) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT
`ifdef LOCK_EN
        , S_LOCKED
`endif
    } state_e;

    state_e         state_q, state_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [m-1:0]   gnt_q, gnt_d;
    logic           ld_c_q, ld_c_d;
    logic [n-1:0]   ld_data_q, ld_data_d;

    logic [m-1:0]   eff_req;
    logic           found;
    logic [PW-1:0]  win_idx;

    // Index k positions after base, wrapped modulo m (m need not be 2^k).
    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= m) s = s - m;
        return PW'(s);
    endfunction

    // ------------------------------------------------------------------------
    // Winner search. The bit granted this cycle is masked so its requester,
    // which drops req only by the next edge, cannot be granted twice. The
    // search starts one past the last winner, so that requester is last.
    // ------------------------------------------------------------------------
    always_comb begin
        eff_req = req & ~gnt_q;
        found   = 1'b0;
        win_idx = ptr_q;
        for (int k = 1; k <= m; k++) begin
            if (!found && eff_req[wrap_idx(ptr_q, k)]) begin
                found   = 1'b1;
                win_idx = wrap_idx(ptr_q, k);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and registered-output logic.
    // ------------------------------------------------------------------------
    // NOTE: every signal gets a default first so no path leaves it unassigned;
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_d   = S_IDLE;
        ptr_d     = ptr_q;
        gnt_d     = '0;
        ld_c_d    = 1'b0;
        ld_data_d = '0;

`ifdef LOCK_EN
        if (state_q == S_LOCKED && req[ptr_q] && lock[ptr_q]) begin
            // Locked owner keeps the register; fresh data every cycle.
            state_d        = S_LOCKED;
            gnt_d[ptr_q]   = 1'b1;
            ld_c_d         = 1'b1;
            ld_data_d      = data[ptr_q*n +: n];
        end else
`endif
        if (found) begin
            state_d          = S_GRANT;
            ptr_d            = win_idx;
            gnt_d[win_idx]   = 1'b1;
            ld_c_d           = 1'b1;
            ld_data_d        = data[win_idx*n +: n];
`ifdef LOCK_EN
            if (lock[win_idx]) state_d = S_LOCKED;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!clr) begin
            // ptr = m-1 makes requester 0 first in the search order.
            // NOTE: ld_data is reset too; the outputs are defined as zero after
            // reset, so the data register cannot be left uninitialised.
            state_q   <= S_IDLE;
            ptr_q     <= PW'(m - 1);
            gnt_q     <= '0;
            ld_c_q    <= 1'b0;
            ld_data_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            ld_c_q    <= ld_c_d;
            ld_data_q <= ld_data_d;
        end
    end

    assign gnt     = gnt_q;
    assign ld_c    = ld_c_q;
    assign ld_data = ld_data_q;
    // Every non-idle state issues exactly one load, so busy tracks ld_c.
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_rr_load_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rr_load_arbiter
//
// Directed bench for rr_load_arbiter (n = 4, m = 4). A table of
// {inputs, expected outputs} records covers reset, single requests,
// rotation, full contention, reset mid-grant and re-request masking. Short
// hand-written sequences cover data stability, a lost req pulse and, when
// LOCK_EN is defined, the locked re-grant. A negedge monitor checks the
// one-hot grant and ld_c/busy consistency every cycle.
// ----------------------------------------------------------------------------
module tb_rr_load_arbiter;

    localparam int N = 4;
    localparam int M = 4;

    logic           clk;
    logic           clr;
    logic [M-1:0]   req;
    logic [M*N-1:0] data;
`ifdef LOCK_EN
    logic [M-1:0]   lock;
`endif
    logic [M-1:0]   gnt;
    logic           ld_c;
    logic [N-1:0]   ld_data;
    logic           busy;

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;

    rr_load_arbiter #(.n(N), .m(M)) dut (
        .clk     (clk),
        .clr     (clr),
        .req     (req),
        .data    (data),
`ifdef LOCK_EN
        .lock    (lock),
`endif
        .gnt     (gnt),
        .ld_c    (ld_c),
        .ld_data (ld_data),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Advance one rising edge and sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Invariants, sampled on the opposite edge.
    always @(negedge clk) begin
        if (mon_en) begin
            check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            check("ld_c_eq_gnt", 32'(ld_c), 32'(|gnt));
            check("busy_eq_ld_c", 32'(busy), 32'(ld_c));
        end
    end

    typedef struct {
        logic           clr;
        logic [M-1:0]   req;
        logic [M*N-1:0] data;
        logic [M-1:0]   gnt;
        logic           ld_c;
        logic [N-1:0]   ld_data;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    initial begin
        // clr, req, data, exp gnt, exp ld_c, exp ld_data
        // Reset for 2 cycles (second with all requests up: reset wins).
        vecs[0]  = '{1'b0, 4'b0000, 16'h0000, 4'b0000, 1'b0, 4'h0};
        vecs[1]  = '{1'b0, 4'b1111, 16'hFFFF, 4'b0000, 1'b0, 4'h0};
        // Single request from 2, slice 2 = A; gone next cycle.
        vecs[2]  = '{1'b1, 4'b0100, 16'h0A00, 4'b0100, 1'b1, 4'hA};
        vecs[3]  = '{1'b1, 4'b0000, 16'h0A00, 4'b0000, 1'b0, 4'h0};
        // Rotation: ptr=2, req=0101 -> search 3,0,1,2 -> 0 then 2.
        vecs[4]  = '{1'b1, 4'b0101, 16'h0B0C, 4'b0001, 1'b1, 4'hC};
        vecs[5]  = '{1'b1, 4'b0100, 16'h0B0C, 4'b0100, 1'b1, 4'hB};
        vecs[6]  = '{1'b1, 4'b0000, 16'h0B0C, 4'b0000, 1'b0, 4'h0};
        // Reset, then full contention; winner drops req for one cycle.
        vecs[7]  = '{1'b0, 4'b1111, 16'h4321, 4'b0000, 1'b0, 4'h0};
        vecs[8]  = '{1'b1, 4'b1111, 16'h4321, 4'b0001, 1'b1, 4'h1};
        vecs[9]  = '{1'b1, 4'b1110, 16'h4321, 4'b0010, 1'b1, 4'h2};
        vecs[10] = '{1'b1, 4'b1101, 16'h4321, 4'b0100, 1'b1, 4'h3};
        vecs[11] = '{1'b1, 4'b1011, 16'h4321, 4'b1000, 1'b1, 4'h4};
        vecs[12] = '{1'b1, 4'b0111, 16'h4321, 4'b0001, 1'b1, 4'h1};
        vecs[13] = '{1'b1, 4'b1110, 16'h4321, 4'b0010, 1'b1, 4'h2};
        // Reset while gnt=0010 is high, then req=1111 -> requester 0 first.
        vecs[14] = '{1'b0, 4'b1101, 16'h4321, 4'b0000, 1'b0, 4'h0};
        vecs[15] = '{1'b1, 4'b1111, 16'h4321, 4'b0001, 1'b1, 4'h1};
        vecs[16] = '{1'b1, 4'b1110, 16'h0030, 4'b0010, 1'b1, 4'h3};
        // Held req one cycle after grant is masked, then re-granted.
        vecs[17] = '{1'b1, 4'b0001, 16'h0005, 4'b0001, 1'b1, 4'h5};
        vecs[18] = '{1'b1, 4'b0001, 16'h0005, 4'b0000, 1'b0, 4'h0};
        vecs[19] = '{1'b1, 4'b0001, 16'h0005, 4'b0001, 1'b1, 4'h5};

        clr  = 1'b0;
        req  = '0;
        data = '0;
`ifdef LOCK_EN
        lock = '0;
`endif

        for (int i = 0; i < NV; i++) begin
            clr  = vecs[i].clr;
            req  = vecs[i].req;
            data = vecs[i].data;
            step();
            mon_en = 1'b1;
            check($sformatf("v%0d_gnt", i),     32'(gnt),     32'(vecs[i].gnt));
            check($sformatf("v%0d_ld_c", i),    32'(ld_c),    32'(vecs[i].ld_c));
            check($sformatf("v%0d_ld_data", i), 32'(ld_data), 32'(vecs[i].ld_data));
        end

        // Data stability: data changes 3 -> C during the grant cycle.
        clr = 1'b0; req = '0; step();
        clr = 1'b1; req = 4'b0010; data = 16'h0030; step();
        check("stab_gnt", 32'(gnt), 32'h2);
        check("stab_ld_data", 32'(ld_data), 32'h3);
        data = 16'h00C0; req = 4'b0000;
        #2;
        check("stab_hold", 32'(ld_data), 32'h3);
        step();
        check("stab_after_ld_c", 32'(ld_c), 32'h0);
        check("stab_after_data", 32'(ld_data), 32'h0);

        // A req pulse that falls between edges is lost.
        #1 req = 4'b0100; data = 16'h0F00;
        #2 req = 4'b0000;
        step();
        check("pulse_lost_gnt", 32'(gnt), 32'h0);

`ifdef LOCK_EN
        // Requester 1 locks for 3 cycles with req[3] waiting.
        clr = 1'b0; req = '0; lock = '0; step();
        clr = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            req  = 4'b1010;
            lock = 4'b0010;
            data = {4'h7, 4'h0, 4'(c), 4'h0};
            step();
            check($sformatf("lock_gnt_c%0d", c), 32'(gnt), 32'h2);
            check($sformatf("lock_data_c%0d", c), 32'(ld_data), 32'(c));
        end
        req = 4'b1000; lock = 4'b0000;
        step();
        check("lock_release_gnt", 32'(gnt), 32'h8);
        check("lock_release_data", 32'(ld_data), 32'h7);
        req = '0; step();
`endif

        @(posedge clk);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
